// File: rtl/run_ctrl.sv
// Run sequencer: streams an initial image into data memory, holds the CPU in
// reset, releases it, counts run cycles until done or timeout, then halts it.
module run_ctrl #(
    parameter int unsigned      HOLD_CYC = 2,
    parameter int unsigned      CW       = 16,
    parameter logic [CW-1:0]    MAX_CYC  = 16'd4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          cpu_reset,
    input  logic          cpu_done,
    output logic          dm_we,
    output logic [7:0]    dm_adr,
    output logic [7:0]    dm_di,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {IDLE, LOAD, HOLD, RUN, FIN, TMO} state_t;

    state_t        state, state_nxt;
    logic [7:0]    addr, addr_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [CW-1:0] cycles_nxt, cyc_inc;
    logic          cpu_reset_nxt, dm_we_nxt, busy_nxt, finished_nxt, timeout_nxt;
    logic [7:0]    dm_adr_nxt, dm_di_nxt;
    logic          accept, load_end, hold_end;

    assign ld_ready = (state == LOAD);
    assign accept   = ld_valid & ld_ready;
    // A beat landing on address 255 closes the image so the address never wraps
    assign load_end = accept & (ld_last | (addr == 8'hFF));
    assign hold_end = (hold_cnt == HOLD_LAST);
    assign cyc_inc  = cycles + CW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            hold_cnt  <= '0;
            cycles    <= '0;
            cpu_reset <= 1'b1;
            dm_we     <= 1'b0;
            dm_adr    <= '0;
            dm_di     <= '0;
            busy      <= 1'b0;
            finished  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            hold_cnt  <= hold_nxt;
            cycles    <= cycles_nxt;
            cpu_reset <= cpu_reset_nxt;
            dm_we     <= dm_we_nxt;
            dm_adr    <= dm_adr_nxt;
            dm_di     <= dm_di_nxt;
            busy      <= busy_nxt;
            finished  <= finished_nxt;
            timeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN, TMO: if (start) state_nxt = LOAD;
            LOAD:           if (load_end) state_nxt = HOLD;
            HOLD:           if (hold_end) state_nxt = RUN;
            RUN: begin
                if (cpu_done)               state_nxt = FIN;
                else if (cyc_inc == MAX_CYC) state_nxt = TMO;
            end
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_nxt      = addr;
        hold_nxt      = hold_cnt;
        cycles_nxt    = cycles;
        cpu_reset_nxt = cpu_reset;
        dm_we_nxt     = 1'b0;
        dm_adr_nxt    = dm_adr;
        dm_di_nxt     = dm_di;
        busy_nxt      = busy;
        finished_nxt  = finished;
        timeout_nxt   = timeout;
        case (state)
            IDLE, FIN, TMO: begin
                cpu_reset_nxt = 1'b1;
                if (start) begin
                    busy_nxt     = 1'b1;
                    finished_nxt = 1'b0;
                    timeout_nxt  = 1'b0;
                    cycles_nxt   = '0;
                    addr_nxt     = '0;
                end
            end
            LOAD: begin
                cpu_reset_nxt = 1'b1;
                if (accept) begin
                    dm_we_nxt  = 1'b1;
                    dm_adr_nxt = addr;
                    dm_di_nxt  = ld_data;
                    addr_nxt   = addr + 8'd1;
                end
                if (load_end) hold_nxt = '0;
            end
            HOLD: begin
                hold_nxt = hold_cnt + HW'(1);
                if (hold_end) cpu_reset_nxt = 1'b0;
            end
            RUN: begin
                if (cpu_done) begin
                    cpu_reset_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                    finished_nxt  = 1'b1;
                end else begin
                    cycles_nxt = cyc_inc;
                    if (cyc_inc == MAX_CYC) begin
                        cpu_reset_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                        timeout_nxt   = 1'b1;
                    end
                end
            end
            default: cpu_reset_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed and randomized load/run sequences checked
// against an image/cycle-count model.
module tb_run_ctrl;

    localparam int unsigned HOLD_CYC = 2;
    localparam int unsigned MAXC     = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        cpu_done = 1'b0;
    logic        ld_ready, cpu_reset, dm_we, busy, finished, timeout;
    logic [7:0]  dm_adr, dm_di;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] wq[$];
    logic [7:0]  img[256];

    run_ctrl #(.HOLD_CYC(HOLD_CYC), .CW(16), .MAX_CYC(16'd20)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .cpu_reset(cpu_reset), .cpu_done(cpu_done),
        .dm_we(dm_we), .dm_adr(dm_adr), .dm_di(dm_di),
        .busy(busy), .finished(finished), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dm_we) wq.push_back({dm_adr, dm_di});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // max_gap < 0 gives a fixed stall of -max_gap cycles before every beat but the first
    task automatic do_load(input int n, input bit use_last, input int max_gap);
        wq.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_fin_clr", 32'(finished), 32'd0);
        chk("load_tmo_clr", 32'(timeout), 32'd0);
        chk("load_cyc_clr", 32'(cycles), 32'd0);
        chk("load_ready", 32'(ld_ready), 32'd1);
        for (int i = 0; i < n; i++) begin
            int gap;
            gap = (max_gap < 0) ? ((i > 0) ? -max_gap : 0) : int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gap; g++) begin
                ld_valid = 1'b0;
                start    = 1'($urandom);
                @(negedge clk);
                chk("gap_we", 32'(dm_we), 32'd0);
            end
            ld_valid = 1'b1;
            ld_data  = img[i];
            ld_last  = use_last && (i == n - 1);
            cpu_done = 1'($urandom);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        start    = 1'b0;
        ld_data  = 8'($urandom);
        chk("ready_drop", 32'(ld_ready), 32'd0);
        for (int h = 0; h < int'(HOLD_CYC); h++) begin
            chk("hold_rst", 32'(cpu_reset), 32'd1);
            cpu_done = 1'($urandom);
            @(negedge clk);
        end
        cpu_done = 1'b0;
        chk("release", 32'(cpu_reset), 32'd0);
        chk("wr_count", 32'(wq.size()), 32'(n));
        for (int i = 0; i < n && i < wq.size(); i++)
            chk("wr_beat", 32'(wq[i]), 32'({8'(i), img[i]}));
    endtask

    // done_at: RUN cycle (1-based) on which cpu_done rises; 0 or beyond MAXC means never
    task automatic do_run(input int done_at, input int hold_after);
        bit fin;
        int len;
        fin = (done_at > 0) && (done_at <= int'(MAXC));
        len = fin ? done_at : int'(MAXC);
        for (int k = 1; k <= len; k++) begin
            cpu_done = (k == done_at);
            @(negedge clk);
            if (k < len) chk("run_cycles", 32'({cpu_reset, busy, cycles}), 32'({2'b01, 16'(k)}));
        end
        cpu_done = 1'b0;
        chk("end_finished", 32'(finished), 32'(fin));
        chk("end_timeout", 32'(timeout), 32'(!fin));
        chk("end_cycles", 32'(cycles), fin ? 32'(done_at - 1) : 32'(MAXC));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_cpu_reset", 32'(cpu_reset), 32'd1);
        if (hold_after > 0) begin
            cpu_done = 1'b1;
            repeat (hold_after) @(negedge clk);
            cpu_done = 1'b0;
            chk("hold_status", 32'({finished, timeout, busy, cpu_reset}), 32'({fin, !fin, 1'b0, 1'b1}));
            chk("hold_cycles", 32'(cycles), fin ? 32'(done_at - 1) : 32'(MAXC));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_status", 32'({finished, timeout}), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        chk("rst_we_ready", 32'({dm_we, ld_ready}), 32'd0);

        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        do_load(4, 1'b1, 0);
        do_run(10, 3);

        img[0] = 8'hA5; img[1] = 8'h5A;
        do_load(2, 1'b1, -2);
        do_run(0, 2);

        for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
        do_load(256, 1'b0, 0);
        do_run(int'(MAXC), 2);

        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        do_load(8, 1'b1, 1);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_cycles", 32'(cycles), 32'd0);
        chk("midrst_flags", 32'({busy, finished, timeout, dm_we, ld_ready}), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(40, 1));
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            do_load(n, 1'b1, 2);
            do_run(int'($urandom_range(25, 0)), int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
